// File: rtl/panda_pcap_buf.sv
// Position-capture buffer: latches posn_i into a FIFO on trigger rising edges while armed,
// and drains it over a valid/ready stream. Define PCAP_TIMESTAMP_EN to add a per-capture timestamp (ts_o).
module panda_pcap_buf #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        trig_i,
    input  logic [31:0] posn_i,
    input  logic [31:0] MAX_NUM,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        act_o,
    output logic        err_o,
    output logic [31:0] count_o
`ifdef PCAP_TIMESTAMP_EN
    ,
    output logic [31:0] ts_o
`endif
);

    localparam int L_DEPTH = 2 ** FIFO_AW;
`ifdef PCAP_TIMESTAMP_EN
    localparam int L_FW = 64;
`else
    localparam int L_FW = 32;
`endif
    localparam logic [FIFO_AW:0]   L_FULL    = (FIFO_AW + 1)'(L_DEPTH);
    localparam logic [FIFO_AW:0]   L_OCC_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] L_PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    logic               r_enable_prev;
    logic               r_trig_prev;
    logic               r_act;
    logic               r_err;
    logic [31:0]        r_count;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_occ;
    logic [L_FW-1:0]    r_mem [L_DEPTH];
`ifdef PCAP_TIMESTAMP_EN
    logic [31:0]        r_ts;
`endif

    logic               w_arm;
    logic               w_capture;
    logic               w_full;
    logic               w_empty;
    logic               w_read;
    logic               w_overflow;
    logic               w_write;
    logic               w_max_hit;
    logic [31:0]        w_count_inc;
    logic [L_FW-1:0]    w_wdata;
    logic [L_FW-1:0]    w_rdata;

    assign w_arm       = enable_i & ~r_enable_prev;
    assign w_capture   = (r_state == S_ACTIVE) & trig_i & ~r_trig_prev;
    assign w_full      = (r_occ == L_FULL);
    assign w_empty     = (r_occ == '0);
    assign w_read      = ~w_empty & data_ready_i;
    // A full FIFO still accepts a capture if the head leaves in the same cycle.
    assign w_overflow  = w_capture & w_full & ~w_read;
    assign w_write     = w_capture & ~w_overflow;
    assign w_count_inc = r_count + 32'd1;
    assign w_max_hit   = w_write & (MAX_NUM != 32'd0) & (w_count_inc == MAX_NUM);

`ifdef PCAP_TIMESTAMP_EN
    assign w_wdata = {r_ts, posn_i};
`else
    assign w_wdata = posn_i;
`endif

    assign w_rdata      = r_mem[r_rd_ptr];
    assign data_valid_o = ~w_empty;
    assign data_o       = w_empty ? 32'd0 : w_rdata[31:0];
`ifdef PCAP_TIMESTAMP_EN
    assign ts_o         = w_empty ? 32'd0 : w_rdata[63:32];
`endif
    assign act_o        = r_act;
    assign err_o        = r_err;
    assign count_o      = r_count;

    // Storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state       <= S_IDLE;
            r_enable_prev <= 1'b0;
            r_trig_prev   <= 1'b0;
            r_act         <= 1'b0;
            r_err         <= 1'b0;
            r_count       <= 32'd0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
`ifdef PCAP_TIMESTAMP_EN
            r_ts          <= 32'd0;
`endif
        end else begin
            r_enable_prev <= enable_i;
            r_trig_prev   <= w_arm ? 1'b0 : trig_i;

            if (w_arm) begin
                // Arming flushes the FIFO, overriding any read this cycle.
                r_state  <= S_ACTIVE;
                r_act    <= 1'b1;
                r_err    <= 1'b0;
                r_count  <= 32'd0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
`ifdef PCAP_TIMESTAMP_EN
                r_ts     <= 32'd0;
`endif
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
                    r_count  <= w_count_inc;
                end
                if (w_read) begin
                    r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
                end
                case ({w_write, w_read})
                    2'b10:   r_occ <= r_occ + L_OCC_ONE;
                    2'b01:   r_occ <= r_occ - L_OCC_ONE;
                    default: r_occ <= r_occ;
                endcase

                case (r_state)
                    S_ACTIVE: begin
`ifdef PCAP_TIMESTAMP_EN
                        r_ts <= r_ts + 32'd1;
`endif
                        if (w_overflow) begin
                            r_state <= S_ERROR;
                            r_act   <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (w_max_hit || !enable_i) begin
                            r_state <= S_DONE;
                            r_act   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/panda_pcap_buf.md
# panda_pcap_buf

Position-capture buffer: the consuming end of position-compare pulse trains. On each rising edge of a trigger (typically a position-compare `pulse_o`) while armed, it latches the 32-bit position bus into a FIFO. The FIFO is drained over a valid/ready stream toward the register/DMA readout. Sits alongside panda_pcomp on the same position bus and shares its enable/act/err semantics.

## Interface
Parameters:
- `FIFO_AW`, 4 — log2 of FIFO depth; depth = 2**FIFO_AW entries (16).

Ports:
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `reset_i`  in  1  synchronous, active-low reset (0 = reset).
- `enable_i`  in  1  arm/disarm level.
- `trig_i`  in  1  capture trigger; only the rising edge is used.
- `posn_i`  in  32  position bus being captured.
- `MAX_NUM`  in  32  captures per arm; 0 = unlimited.
- `data_o`  out  32  head-of-FIFO captured position.
- `data_valid_o`  out  1  `data_o` holds a valid entry.
- `data_ready_i`  in  1  consumer accepts; a transfer occurs when valid && ready.
- `act_o`  out  1  high while armed and capturing.
- `err_o`  out  1  sticky overflow flag, cleared on the next arm.
- `count_o`  out  32  captures accepted since the last arm.

## Operation
- States: IDLE, ACTIVE, DONE, ERROR.
- IDLE→ACTIVE on the `enable_i` 0→1 edge (registered previous value). The same cycle clears `count_o` and `err_o`, flushes the FIFO, and clears the trigger edge history.
- ACTIVE: a capture is a cycle with `trig_i`=1 while its registered previous value is 0. The capture writes that cycle's `posn_i` into the FIFO and increments `count_o`.
- ACTIVE→DONE when `enable_i`=0, or when `count_o` reaches a non-zero `MAX_NUM` on a capture. The capture that reaches `MAX_NUM` is stored.
- ACTIVE→ERROR on a capture while the FIFO is full and no read occurs that cycle. The capture is discarded, `count_o` does not increment, and `err_o` is set.
- DONE, ERROR: ignore triggers. Return to ACTIVE only via a new `enable_i` rising edge. If `enable_i` stays high, `enable_i` must fall and rise again.
- The FIFO keeps draining in every state. Arming flushes unread entries; flush takes priority over a simultaneous read.
- Simultaneous read and capture when full: both happen and occupancy stays at depth. Simultaneous read and capture at any other occupancy: occupancy unchanged.
- `count_o` is 32-bit and wraps 0xFFFFFFFF→0 when `MAX_NUM`=0. Pointers wrap modulo depth. Full = occupancy==depth; empty = occupancy==0.
- Stream rule: once `data_valid_o` is high, `data_o` is held stable until the transfer.

## Timing
- Reset (`reset_i`=0 at a clock edge): state IDLE, FIFO empty, `data_o`=0, `data_valid_o`=0, `act_o`=0, `err_o`=0, `count_o`=0.
- Reset mid-operation discards FIFO contents and the state within one cycle.
- Capture latency: edge seen in cycle N → `count_o` updated and entry written at the end of N → `data_valid_o`=1 in N+1 if the FIFO was empty.
- Read: transfer at cycle M → next entry (or `data_valid_o`=0) in M+1. Sustained throughput is 1 entry per cycle.
- `act_o` is registered. It rises the cycle after the arm edge and falls the cycle after the terminating condition. The triggering capture of an overflow sees `act_o`=1; `err_o`=1 from the next cycle.
- Triggers closer than 1 low cycle apart cannot form an edge. Minimum trigger period is 2 cycles.

## Configuration
- `PCAP_TIMESTAMP_EN` defined:
  - Adds output `ts_o` [31:0] and a 32-bit timestamp counter. The counter zeroes on arm and increments every cycle while ACTIVE.
  - FIFO width becomes 64 bits; each capture stores `posn_i` and the timestamp of the capture cycle.
  - `ts_o` follows the same valid/ready rules as `data_o`.
- `PCAP_TIMESTAMP_EN` undefined: no `ts_o` port, no counter, FIFO is 32 bits wide.

## Test plan
- Basic capture: arm with `MAX_NUM`=3, `data_ready_i`=1; pulse `trig_i` with `posn_i`=100, 200, 300 → stream 100, 200, 300. `count_o`=3, DONE, `act_o` falls after the third capture, `err_o`=0.
- Overflow: `data_ready_i`=0, `MAX_NUM`=0, 17 triggers → 16 entries stored, `err_o`=1, `act_o`=0, `count_o`=16. Then raise `data_ready_i` → 16 values drain in order, then `data_valid_o`=0.
- Full with simultaneous read: FIFO full, capture in the same cycle as a transfer → no error, occupancy stays 16, `count_o` increments.
- Level trigger: hold `trig_i` high for 10 cycles → exactly 1 capture. Disarm mid-run → DONE and triggers ignored. Re-arm → `count_o`=0, FIFO empty, `err_o`=0.
- Mid-run reset: `reset_i`=0 for 1 cycle with 5 entries queued → all outputs at reset values the next cycle.
- With `PCAP_TIMESTAMP_EN`: triggers at 5 and 12 cycles after `act_o` rises → `ts_o` values differ by exactly 7, each paired with its position.
